alu_sequencer: RTL and testbench

- Drives the 8-bit combinational ALU as its initiator.
- Accepts register-level commands over a valid/ready handshake and issues operands and opcode to the ALU.
- Writes the ALU result back into a 4-entry x 8-bit register file.
- Sits between instruction decode (upstream) and the ALU (downstream); this is the first clocked consumer of the ALU.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu.sv | 24 ++
 rtl/reg_file_nx8.sv | 42 ++++
 rtl/alu_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_sequencer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU/sequencer definitions: opcodes, sequencer state encoding, default width.
// No logic; constants and types only.
package alu_pkg;

    localparam int ALU_W = 8;

    localparam logic [2:0] OP_ADD       = 3'd0;
    localparam logic [2:0] OP_SUB       = 3'd1;
    localparam logic [2:0] OP_PASS      = 3'd2;
    localparam logic [2:0] OP_MAX_LEGAL = 3'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } seq_state_t;

endpackage

// File: rtl/alu.sv
// Combinational W-bit ALU: ADD, SUB, PASS(b), modulo 2^W; unknown opcodes yield 0.
// Latency: zero cycles. Backpressure: none, purely combinational.
module alu
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic [W-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_PASS: result = b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/reg_file_nx8.sv
// NREGS x W register file: one synchronous write port, two operand read ports, one debug read port.
// Latency: writes visible after the edge; reads combinational with no write bypass. Backpressure: none.
module reg_file_nx8 #(
    parameter int NREGS = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(NREGS)-1:0] ra_addr,
    output logic [W-1:0]             ra_data,
    input  logic [$clog2(NREGS)-1:0] rb_addr,
    output logic [W-1:0]             rb_data,
    input  logic [$clog2(NREGS)-1:0] rd_sel,
    output logic [W-1:0]             rd_data
);

    logic [W-1:0] regs_q [NREGS];
    logic [W-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign ra_data = regs_q[ra_addr];
    assign rb_data = regs_q[rb_addr];
    assign rd_data = regs_q[rd_sel];

endmodule

// File: rtl/alu_sequencer.sv
// Register-level command sequencer driving an external combinational ALU; optional z/n flags under ALU_SEQ_FLAGS_EN.
// Latency: accept edge registers ALU operands, next edge writes back and pulses done (1 command per 2 cycles).
// Backpressure: cmd_ready is low for the single EXEC cycle; illegal opcodes are consumed in IDLE and flagged on err.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int NREGS = 4,
    parameter int W     = ALU_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [$clog2(NREGS)-1:0] cmd_dst,
    input  logic [$clog2(NREGS)-1:0] cmd_src,
    input  logic                     cmd_use_imm,
    input  logic [W-1:0]             cmd_imm,
    output logic [W-1:0]             alu_a,
    output logic [W-1:0]             alu_b,
    output logic [2:0]               alu_op,
    input  logic [W-1:0]             alu_result,
    output logic                     done,
    output logic                     err,
`ifdef ALU_SEQ_FLAGS_EN
    output logic                     z_flag,
    output logic                     n_flag,
`endif
    input  logic [$clog2(NREGS)-1:0] rd_sel,
    output logic [W-1:0]             rd_data
);

    localparam int AW = $clog2(NREGS);

    seq_state_t    state_q, state_d;
    logic [W-1:0]  alu_a_q, alu_a_d;
    logic [W-1:0]  alu_b_q, alu_b_d;
    logic [2:0]    alu_op_q, alu_op_d;
    logic [AW-1:0] dst_q, dst_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          wb_en;
    logic [W-1:0]  ra_data;
    logic [W-1:0]  rb_data;

    // Writeback happens on the edge that leaves EXEC, using the ALU's settled result.
    assign wb_en = (state_q == ST_EXEC);

    reg_file_nx8 #(
        .NREGS (NREGS),
        .W     (W)
    ) u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_en),
        .waddr   (dst_q),
        .wdata   (alu_result),
        .ra_addr (cmd_dst),
        .ra_data (ra_data),
        .rb_addr (cmd_src),
        .rb_data (rb_data),
        .rd_sel  (rd_sel),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d  = state_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        dst_d    = dst_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op > OP_MAX_LEGAL) begin
                        err_d = 1'b1;
                    end else begin
                        alu_a_d  = ra_data;
                        alu_b_d  = cmd_use_imm ? cmd_imm : rb_data;
                        alu_op_d = cmd_op;
                        dst_d    = cmd_dst;
                        state_d  = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            dst_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            dst_q    <= dst_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic z_flag_q, z_flag_d;
    logic n_flag_q, n_flag_d;

    always_comb begin
        z_flag_d = z_flag_q;
        n_flag_d = n_flag_q;
        if (wb_en) begin
            z_flag_d = (alu_result == '0);
            n_flag_d = alu_result[W-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_flag_q <= 1'b0;
            n_flag_q <= 1'b0;
        end else begin
            z_flag_q <= z_flag_d;
            n_flag_q <= n_flag_d;
        end
    end

    assign z_flag = z_flag_q;
    assign n_flag = n_flag_q;
`endif

    assign cmd_ready = (state_q == ST_IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer paired with the combinational alu; scoreboard of expected writebacks.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int NREGS = 4;
    localparam int W     = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = '0;
    logic [1:0]   cmd_dst = '0;
    logic [1:0]   cmd_src = '0;
    logic         cmd_use_imm = 1'b0;
    logic [W-1:0] cmd_imm = '0;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [2:0]   alu_op;
    logic         done, err;
    logic [1:0]   rd_sel = '0;
    logic [W-1:0] rd_data;
`ifdef ALU_SEQ_FLAGS_EN
    logic         z_flag, n_flag;
`endif

    always #5 clk = ~clk;

    alu #(.W(W)) u_alu (.a(alu_a), .b(alu_b), .op(alu_op), .result(alu_result));

    alu_sequencer #(.NREGS(NREGS), .W(W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .done(done), .err(err),
`ifdef ALU_SEQ_FLAGS_EN
        .z_flag(z_flag), .n_flag(n_flag),
`endif
        .rd_sel(rd_sel), .rd_data(rd_data)
    );

    typedef struct {
        logic [1:0]   dst;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] data;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         last_exp;
    logic [W-1:0] exp_r [NREGS];
    int           n_checks = 0;
    int           n_fail   = 0;

    function automatic logic [W-1:0] model_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = b;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic model_reset;
        for (int i = 0; i < NREGS; i++) exp_r[i] = '0;
        last_exp = '{dst: 2'd0, op: 3'd0, a: '0, b: '0, data: '0};
        sb_q.delete();
    endtask

    task automatic push_exp(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] src,
                            input logic ui, input logic [W-1:0] imm);
        exp_t e;
        e.dst  = dst;
        e.op   = op;
        e.a    = exp_r[dst];
        e.b    = ui ? imm : exp_r[src];
        e.data = model_alu(op, e.a, e.b);
        last_exp = e;
        sb_q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issues one legal command, then waits (bounded) for done and pops the scoreboard.
    task automatic do_cmd(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] src,
                          input logic ui, input logic [W-1:0] imm,
                          output logic rdy0, output logic rdy1,
                          output logic [W-1:0] a_s, output logic [W-1:0] b_s, output logic [2:0] op_s,
                          output int edges, output exp_t e, output logic [W-1:0] got,
                          output logic done_after);
        cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_use_imm = ui; cmd_imm = imm;
        cmd_valid = 1'b1;
        rdy0 = cmd_ready;
        push_exp(op, dst, src, ui, imm);
        tick;
        cmd_valid = 1'b0;
        rdy1 = cmd_ready; a_s = alu_a; b_s = alu_b; op_s = alu_op;
        edges = 1;
        while (done !== 1'b1 && edges < 6) begin
            tick;
            edges++;
        end
        e = sb_q.pop_front();
        exp_r[e.dst] = e.data;
        rd_sel = e.dst;
        #1;
        got = rd_data;
        @(posedge clk);
        #1;
        done_after = done;
    endtask

    task automatic test_reset;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        n_checks++; if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: done=%b err=%b want 0", done, err); end
        n_checks++; if (alu_a !== 8'd0 || alu_b !== 8'd0 || alu_op !== 3'd0) begin
            n_fail++; $display("FAIL reset_alu: a=%0d b=%0d op=%0d want 0", alu_a, alu_b, alu_op); end
        for (int i = 0; i < NREGS; i++) begin
            rd_sel = 2'(i);
            #1;
            n_checks++; if (rd_data !== exp_r[i]) begin n_fail++; $display("FAIL reset_R%0d: got %0d want %0d", i, rd_data, exp_r[i]); end
        end
`ifdef ALU_SEQ_FLAGS_EN
        n_checks++; if (z_flag !== 1'b0 || n_flag !== 1'b0) begin n_fail++; $display("FAIL reset_flags: z=%b n=%b want 0", z_flag, n_flag); end
`endif
        tick;
    endtask

    task automatic test_pass_add;
        logic r0, r1, da; logic [W-1:0] a_s, b_s, got; logic [2:0] op_s; int edges; exp_t e;
        do_cmd(OP_PASS, 2'd1, 2'd0, 1'b1, 8'd170, r0, r1, a_s, b_s, op_s, edges, e, got, da);
        n_checks++; if (r0 !== 1'b1 || r1 !== 1'b0) begin n_fail++; $display("FAIL pass_ready: got %b%b want 10", r0, r1); end
        n_checks++; if (b_s !== e.b || op_s !== e.op) begin n_fail++; $display("FAIL pass_alu_in: b=%0d op=%0d want b=%0d op=%0d", b_s, op_s, e.b, e.op); end
        n_checks++; if (edges !== 2) begin n_fail++; $display("FAIL pass_latency: got %0d edges want 2", edges); end
        n_checks++; if (got !== e.data) begin n_fail++; $display("FAIL pass_R1: got %0d want %0d", got, e.data); end
        n_checks++; if (da !== 1'b0) begin n_fail++; $display("FAIL pass_done_pulse: done still %b want 0", da); end
        do_cmd(OP_ADD, 2'd1, 2'd0, 1'b1, 8'd85, r0, r1, a_s, b_s, op_s, edges, e, got, da);
        n_checks++; if (a_s !== e.a || b_s !== e.b || op_s !== e.op) begin
            n_fail++; $display("FAIL add_alu_in: a=%0d b=%0d op=%0d want %0d %0d %0d", a_s, b_s, op_s, e.a, e.b, e.op); end
        n_checks++; if (edges !== 2) begin n_fail++; $display("FAIL add_latency: got %0d edges want 2", edges); end
        n_checks++; if (got !== 8'd255) begin n_fail++; $display("FAIL add_R1: got %0d want 255", got); end
`ifdef ALU_SEQ_FLAGS_EN
        n_checks++; if (n_flag !== 1'b1 || z_flag !== 1'b0) begin n_fail++; $display("FAIL add_flags: z=%b n=%b want z=0 n=1", z_flag, n_flag); end
`endif
    endtask

    task automatic test_wraparound;
        logic r0, r1, da; logic [W-1:0] a_s, b_s, got; logic [2:0] op_s; int edges; exp_t e;
        do_cmd(OP_ADD, 2'd1, 2'd0, 1'b1, 8'd1, r0, r1, a_s, b_s, op_s, edges, e, got, da);
        n_checks++; if (got !== e.data || got !== 8'd0) begin n_fail++; $display("FAIL wrap_add: got %0d want %0d", got, e.data); end
`ifdef ALU_SEQ_FLAGS_EN
        n_checks++; if (z_flag !== 1'b1 || n_flag !== 1'b0) begin n_fail++; $display("FAIL wrap_add_flags: z=%b n=%b want z=1 n=0", z_flag, n_flag); end
`endif
        do_cmd(OP_SUB, 2'd2, 2'd0, 1'b1, 8'd1, r0, r1, a_s, b_s, op_s, edges, e, got, da);
        n_checks++; if (got !== e.data || got !== 8'd255) begin n_fail++; $display("FAIL wrap_sub: got %0d want %0d", got, e.data); end
        n_checks++; if (edges !== 2) begin n_fail++; $display("FAIL wrap_sub_latency: got %0d edges want 2", edges); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] rdy; logic d1, d2; logic [W-1:0] bhold, r3a, r3b; exp_t e1, e2;
        cmd_op = OP_PASS; cmd_dst = 2'd3; cmd_src = 2'd0; cmd_use_imm = 1'b1; cmd_imm = 8'd42;
        cmd_valid = 1'b1;
        rdy[3] = cmd_ready;
        push_exp(OP_PASS, 2'd3, 2'd0, 1'b1, 8'd42);
        tick;
        rdy[2] = cmd_ready;
        // These values arrive while busy and must not disturb the PASS in flight.
        cmd_op = OP_SUB; cmd_src = 2'd3; cmd_use_imm = 1'b0; cmd_imm = 8'hff;
        #1;
        bhold = alu_b;
        tick;
        rdy[1] = cmd_ready; d1 = done;
        e1 = sb_q.pop_front();
        exp_r[e1.dst] = e1.data;
        rd_sel = 2'd3;
        #1;
        r3a = rd_data;
        push_exp(OP_SUB, 2'd3, 2'd3, 1'b0, 8'hff);
        tick;
        rdy[0] = cmd_ready;
        cmd_valid = 1'b0;
        tick;
        d2 = done;
        e2 = sb_q.pop_front();
        exp_r[e2.dst] = e2.data;
        #1;
        r3b = rd_data;
        n_checks++; if (rdy !== 4'b1010) begin n_fail++; $display("FAIL b2b_ready_seq: got %b want 1010", rdy); end
        n_checks++; if (bhold !== 8'd42) begin n_fail++; $display("FAIL b2b_ignore_busy: alu_b=%0d want 42", bhold); end
        n_checks++; if (d1 !== 1'b1 || d2 !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b%b want 11", d1, d2); end
        n_checks++; if (r3a !== e1.data) begin n_fail++; $display("FAIL b2b_pass_R3: got %0d want %0d", r3a, e1.data); end
        n_checks++; if (r3b !== e2.data || r3b !== 8'd0) begin n_fail++; $display("FAIL b2b_sub_R3: got %0d want %0d", r3b, e2.data); end
        n_checks++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL b2b_sb_empty: got %0d entries want 0", sb_q.size()); end
        tick;
    endtask

    task automatic test_illegal_op;
        logic e_at, d_at, r_at, e_after;
        cmd_op = 3'd5; cmd_dst = 2'd1; cmd_src = 2'd2; cmd_use_imm = 1'b1; cmd_imm = 8'd99;
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
        e_at = err; d_at = done; r_at = cmd_ready;
        n_checks++; if (alu_a !== last_exp.a || alu_b !== last_exp.b || alu_op !== last_exp.op) begin
            n_fail++; $display("FAIL illegal_alu_hold: a=%0d b=%0d op=%0d want %0d %0d %0d",
                               alu_a, alu_b, alu_op, last_exp.a, last_exp.b, last_exp.op); end
        tick;
        e_after = err;
        n_checks++; if (e_at !== 1'b1 || e_after !== 1'b0) begin n_fail++; $display("FAIL illegal_err_pulse: got %b%b want 10", e_at, e_after); end
        n_checks++; if (d_at !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL illegal_no_done: got %b%b want 00", d_at, done); end
        n_checks++; if (r_at !== 1'b1 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_ready: got %b%b want 11", r_at, cmd_ready); end
        for (int i = 0; i < NREGS; i++) begin
            rd_sel = 2'(i);
            #1;
            n_checks++; if (rd_data !== exp_r[i]) begin n_fail++; $display("FAIL illegal_R%0d: got %0d want %0d", i, rd_data, exp_r[i]); end
        end
`ifdef ALU_SEQ_FLAGS_EN
        n_checks++; if (z_flag !== 1'b1 || n_flag !== 1'b0) begin n_fail++; $display("FAIL illegal_flags: z=%b n=%b want z=1 n=0", z_flag, n_flag); end
`endif
        tick;
    endtask

    task automatic test_reset_mid_exec;
        logic r0, r1, da; logic [W-1:0] a_s, b_s, got; logic [2:0] op_s; int edges; exp_t e;
        cmd_op = OP_ADD; cmd_dst = 2'd0; cmd_src = 2'd0; cmd_use_imm = 1'b1; cmd_imm = 8'd100;
        cmd_valid = 1'b1;
        push_exp(OP_ADD, 2'd0, 2'd0, 1'b1, 8'd100);
        tick;
        cmd_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++; if (done !== 1'b0 || cmd_ready !== 1'b1 || alu_a !== 8'd0 || alu_b !== 8'd0) begin
            n_fail++; $display("FAIL rstexec_async: done=%b ready=%b a=%0d b=%0d want 0 1 0 0", done, cmd_ready, alu_a, alu_b); end
        tick;
        rst = 1'b0;
        rd_sel = 2'd0;
        for (int i = 0; i < NREGS; i++) begin
            rd_sel = 2'(i);
            #1;
            n_checks++; if (rd_data !== exp_r[i]) begin n_fail++; $display("FAIL rstexec_R%0d: got %0d want %0d", i, rd_data, exp_r[i]); end
        end
        tick;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstexec_no_done: got %b want 0", done); end
`ifdef ALU_SEQ_FLAGS_EN
        n_checks++; if (z_flag !== 1'b0 || n_flag !== 1'b0) begin n_fail++; $display("FAIL rstexec_flags: z=%b n=%b want 0", z_flag, n_flag); end
`endif
        do_cmd(OP_ADD, 2'd0, 2'd0, 1'b1, 8'd100, r0, r1, a_s, b_s, op_s, edges, e, got, da);
        n_checks++; if (edges !== 2) begin n_fail++; $display("FAIL rstexec_next_latency: got %0d edges want 2", edges); end
        n_checks++; if (got !== e.data || got !== 8'd100) begin n_fail++; $display("FAIL rstexec_next_R0: got %0d want %0d", got, e.data); end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_pass_add();
        test_wraparound();
        test_back_to_back();
        test_illegal_op();
        test_reset_mid_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
